// File: rtl/rom_read_arbiter.sv
// Round-robin burst arbiter sharing one synchronous ROM between NUM_REQ requesters.
// Optional per-requester grant counters are enabled with `define ROM_ARB_STATS_EN.
module rom_read_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter int LEN_W       = 4,
  parameter int ROM_LATENCY = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]    req_len,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        busy,
  output logic [ADDR_W-1:0]           rom_address,
  output logic                        rom_rden,
  input  logic [DATA_W-1:0]           rom_q
`ifdef ROM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]       grant_cnt
`endif
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ID_W-1:0]    ID_LAST  = ID_W'(NUM_REQ - 1);
  localparam logic [ID_W-1:0]    ID_ONE   = ID_W'(1);
  localparam logic [ADDR_W-1:0]  ADDR_ONE = ADDR_W'(1);
  localparam logic [LEN_W-1:0]   LEN_ONE  = LEN_W'(1);
  localparam logic [NUM_REQ-1:0] REQ_ONE  = NUM_REQ'(1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t                   r_state;
  logic [ID_W-1:0]          r_ptr;
  logic [ID_W-1:0]          r_id;
  logic [ADDR_W-1:0]        r_cur_addr;
  logic [LEN_W-1:0]         r_beats;
  logic [NUM_REQ-1:0]       r_gnt;
  logic                     r_rom_rden;
  logic [ADDR_W-1:0]        r_rom_address;
  logic [ROM_LATENCY-1:0]   r_tag_vld;
  logic [ID_W-1:0]          r_tag_id [ROM_LATENCY];

  logic                     w_found;
  logic [ID_W-1:0]          w_winner;
  logic [ID_W-1:0]          w_next_ptr;
  logic [ADDR_W-1:0]        w_start_addr;
  logic [LEN_W-1:0]         w_start_len;
  logic                     w_arb_slot;

  // Requests are level-held until their gnt pulse; the arbiter only looks at req
  // in IDLE or on the last beat of a burst, so a drop before gnt withdraws it.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req[(int'(r_ptr) + i) % NUM_REQ]) begin
        w_found  = 1'b1;
        w_winner = ID_W'((int'(r_ptr) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    w_next_ptr   = (w_winner == ID_LAST) ? '0 : w_winner + ID_ONE;
    w_start_addr = req_addr[int'(w_winner)*ADDR_W +: ADDR_W];
    w_start_len  = req_len[int'(w_winner)*LEN_W +: LEN_W];
    w_arb_slot   = (r_state == S_IDLE) || (r_beats == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_id          <= '0;
      r_cur_addr    <= '0;
      r_beats       <= '0;
      r_gnt         <= '0;
      r_rom_rden    <= 1'b0;
      r_rom_address <= '0;
      r_tag_vld     <= '0;
      for (int k = 0; k < ROM_LATENCY; k++) r_tag_id[k] <= '0;
    end else begin
      // Tag pipe mirrors the ROM pipeline: head captures the beat being issued now.
      r_tag_vld[0] <= r_rom_rden;
      r_tag_id[0]  <= r_id;
      for (int k = 1; k < ROM_LATENCY; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_id[k]  <= r_tag_id[k-1];
      end

      if (w_arb_slot) begin
        if (w_found) begin
          r_state       <= S_BURST;
          r_id          <= w_winner;
          r_ptr         <= w_next_ptr;
          r_gnt         <= REQ_ONE << w_winner;
          r_rom_rden    <= 1'b1;
          r_rom_address <= w_start_addr;
          r_cur_addr    <= w_start_addr + ADDR_ONE;
          r_beats       <= w_start_len;
        end else begin
          r_state    <= S_IDLE;
          r_gnt      <= '0;
          r_rom_rden <= 1'b0;
        end
      end else begin
        r_gnt         <= '0;
        r_rom_rden    <= 1'b1;
        r_rom_address <= r_cur_addr;
        r_cur_addr    <= r_cur_addr + ADDR_ONE;
        r_beats       <= r_beats - LEN_ONE;
      end
    end
  end

  always_comb begin
    gnt         = r_gnt;
    rom_rden    = r_rom_rden;
    rom_address = r_rom_address;
    busy        = (r_state != S_IDLE) || (|r_tag_vld);
    rvalid      = r_tag_vld[ROM_LATENCY-1] ? (REQ_ONE << r_tag_id[ROM_LATENCY-1]) : '0;
    rdata       = r_tag_vld[ROM_LATENCY-1] ? rom_q : '0;
  end

`ifdef ROM_ARB_STATS_EN
  logic [15:0] r_grant_cnt [NUM_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) r_grant_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (r_gnt[i] && (r_grant_cnt[i] != 16'hFFFF)) r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) grant_cnt[i*16 +: 16] = r_grant_cnt[i];
  end
`endif

endmodule
